// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared types and constants for the UART packet deframer.
// State encoding, default sync marker, checksum width and update helper.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CHK_W         = 8;

    function automatic logic [CHK_W-1:0] chk_add(
        input logic [CHK_W-1:0] c,
        input logic [7:0]       b
    );
        return c ^ b;
    endfunction

endpackage

// File: rtl/pkt_idle_timer.sv
// pkt_idle_timer: counts idle clocks while run is high, restarting on clear.
// expired is asserted once LIMIT idle clocks have elapsed.
module pkt_idle_timer #(
    parameter int unsigned LIMIT = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // Idle counter: restarts on a pop or outside a packet, holds at the limit
    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: recovers SYNC/CMD/LEN/payload/CHK packets from a FWFT FIFO.
// Optional inter-byte idle timeout is built when DEFRAMER_TIMEOUT_EN is defined.
module uart_pkt_deframer
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic       clk_rx,
  input  logic       rst_clk_rx,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  output logic       read_en,
  output logic [7:0] out_data,
  output logic [7:0] out_cmd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [7:0] err_cnt
);

  pkt_state_t       r_state;
  pkt_state_t       w_next;
  logic [7:0]       r_cmd;
  logic [7:0]       r_len;
  logic [CHK_W-1:0] r_chk;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_err_cnt;
  logic             w_read_en;
  logic             w_timeout;
  logic             w_chk_pop;
  logic             w_err_evt;

`ifdef DEFRAMER_TIMEOUT_EN
  pkt_idle_timer #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_idle (
    .clk     (clk_rx),
    .rst     (rst_clk_rx),
    .clear   (w_read_en),
    .run     (r_state != ST_HUNT),
    .expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_read_en = 1'b0;
    if (!rst_clk_rx && !w_timeout && rx_data_rdy) begin
      if (r_state == ST_PAYLOAD) begin
        w_read_en = !r_out_valid || out_ready;
      end else begin
        w_read_en = 1'b1;
      end
    end
    case (r_state)
      ST_HUNT: begin
        if (w_read_en && rx_data == SYNC_BYTE) begin
          w_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_read_en) begin
          w_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_read_en) begin
          w_next = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_read_en && r_len == 8'd1) begin
          w_next = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_read_en) begin
          w_next = ST_HUNT;
        end
      end
      default: w_next = ST_HUNT;
    endcase
    if (w_timeout) begin
      w_next = ST_HUNT;
    end
  end

  assign w_chk_pop = (r_state == ST_CHK) && w_read_en;
  assign w_err_evt = (w_chk_pop && (rx_data != r_chk)) || w_timeout;

  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      r_cmd <= 8'd0;
      r_len <= 8'd0;
      r_chk <= '0;
    end else if (w_read_en) begin
      case (r_state)
        ST_CMD: begin
          r_cmd <= rx_data;
          r_chk <= rx_data;
        end
        ST_LEN: begin
          r_len <= rx_data;
          r_chk <= chk_add(r_chk, rx_data);
        end
        ST_PAYLOAD: begin
          r_len <= r_len - 8'd1;
          r_chk <= chk_add(r_chk, rx_data);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_last  <= 1'b0;
    end else if (r_state == ST_PAYLOAD && w_read_en) begin
      r_out_valid <= 1'b1;
      r_out_data  <= rx_data;
      r_out_last  <= (r_len == 8'd1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_done <= w_chk_pop;
      r_err  <= w_err_evt;
      if (w_err_evt && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign read_en   = w_read_en;
  assign out_data  = r_out_data;
  assign out_cmd   = r_cmd;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign pkt_done  = r_done;
  assign pkt_err   = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// tb_uart_pkt_deframer: scoreboard bench with a packet-level reference model.
// Build with DEFRAMER_TIMEOUT_EN to include the idle-timeout scenario.
module tb_uart_pkt_deframer;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       last;
  } pay_t;

  typedef struct packed {
    logic done;
    logic err;
  } evt_t;

  logic       clk_rx = 1'b0;
  logic       rst_clk_rx = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_rdy = 1'b0;
  logic       read_en;
  logic [7:0] out_data;
  logic [7:0] out_cmd;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       pkt_done;
  logic       pkt_err;
  logic [7:0] err_cnt;

  logic [7:0] fifo[$];
  logic [7:0] pl[$];
  pay_t       pay_q[$];
  evt_t       evt_q[$];

  int  checks = 0;
  int  failures = 0;
  int  model_err = 0;
  int  rdy_pct = 80;
  int  ready_pct = 70;
  bit  force_low = 1'b0;
  bit  pop_now = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_d = 8'd0;
  logic       prev_l = 1'b0;

  always #5 clk_rx = ~clk_rx;

  uart_pkt_deframer #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_rx      (clk_rx),
    .rst_clk_rx  (rst_clk_rx),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .read_en     (read_en),
    .out_data    (out_data),
    .out_cmd     (out_cmd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .err_cnt     (err_cnt)
  );

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bit gate;
    gate = ($urandom_range(99) < rdy_pct);
    rx_data_rdy = gate && (fifo.size() > 0);
    rx_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    if (force_low) out_ready = 1'b0;
    else out_ready = ($urandom_range(99) < ready_pct);
  endtask

  always @(posedge clk_rx) begin
    logic [7:0] tmp;
    #1;
    if (pop_now && fifo.size() > 0) tmp = fifo.pop_front();
    pop_now = 1'b0;
    drive();
  end

  always @(negedge clk_rx) pop_now = read_en;

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] flip);
    logic [7:0] c;
    pay_t p;
    evt_t e;
    c = cmd ^ 8'(pl.size());
    foreach (pl[i]) c = c ^ pl[i];
    fifo.push_back(8'hA5);
    fifo.push_back(cmd);
    fifo.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      fifo.push_back(pl[i]);
      p.cmd = cmd;
      p.data = pl[i];
      p.last = (i == pl.size() - 1);
      pay_q.push_back(p);
    end
    fifo.push_back(c ^ flip);
    e.done = 1'b1;
    e.err = (flip != 8'd0);
    evt_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || pay_q.size() != 0 ||
            evt_q.size() != 0) && n < 3000) begin
      @(negedge clk_rx);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL drain_timeout bytes=%0d outs=%0d evts=%0d required=0",
               fifo.size(), pay_q.size(), evt_q.size());
    end
    repeat (3) @(negedge clk_rx);
  endtask

  always @(negedge clk_rx) begin
    pay_t p;
    evt_t e;
    if (rst_clk_rx) begin
      prev_stall = 1'b0;
    end else begin
      chk8("read_en_without_rdy",
           {7'd0, read_en && !rx_data_rdy}, 8'd0);
      if (prev_stall) begin
        chk8("hold_valid", {7'd0, out_valid}, 8'd1);
        chk8("hold_data", out_data, prev_d);
        chk8("hold_last", {7'd0, out_last}, {7'd0, prev_l});
      end
      if (out_valid && out_ready) begin
        if (pay_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%02h required=none",
                   out_data);
        end else begin
          p = pay_q.pop_front();
          chk8("out_data", out_data, p.data);
          chk8("out_cmd", out_cmd, p.cmd);
          chk8("out_last", {7'd0, out_last}, {7'd0, p.last});
        end
      end
      if (pkt_done || pkt_err) begin
        if (evt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse done=%0d err=%0d required=none",
                   pkt_done, pkt_err);
        end else begin
          e = evt_q.pop_front();
          chk8("done_err", {6'd0, pkt_done, pkt_err},
               {6'd0, e.done, e.err});
          if (e.err && model_err < 255) model_err++;
          chk8("err_cnt", err_cnt, 8'(model_err));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  initial begin
    int n;
    int stall_pops;
    logic [7:0] b;
    drive();
    repeat (3) @(negedge clk_rx);
    chk8("rst_read_en", {7'd0, read_en}, 8'd0);
    chk8("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk8("rst_out_last", {7'd0, out_last}, 8'd0);
    chk8("rst_out_data", out_data, 8'd0);
    chk8("rst_out_cmd", out_cmd, 8'd0);
    chk8("rst_pkt_done", {7'd0, pkt_done}, 8'd0);
    chk8("rst_pkt_err", {7'd0, pkt_err}, 8'd0);
    chk8("rst_err_cnt", err_cnt, 8'd0);
    @(posedge clk_rx);
    #2 rst_clk_rx = 1'b0;

    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h10, 8'h00);
    drain();
    send_pkt(8'h10, 8'h07);
    drain();

    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    pl.delete();
    send_pkt(8'h20, 8'h00);
    drain();

    rdy_pct = 100;
    ready_pct = 100;
    pl = '{8'h41, 8'h42, 8'h43, 8'h44};
    send_pkt(8'h30, 8'h00);
    n = 0;
    while (!(out_valid && out_ready) && n < 200) begin
      @(negedge clk_rx);
      n++;
    end
    chk8("bp_first_byte_seen", {7'd0, n < 200}, 8'd1);
    force_low = 1'b1;
    stall_pops = 0;
    repeat (5) begin
      @(negedge clk_rx);
      if (read_en) stall_pops++;
    end
    chk8("bp_pops_during_stall", 8'(stall_pops), 8'd0);
    force_low = 1'b0;
    drain();

    rdy_pct = 80;
    ready_pct = 70;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(3)) begin
        b = 8'($urandom_range(255));
        if (b == 8'hA5) b = 8'h5A;
        fifo.push_back(b);
      end
      pl.delete();
      repeat ($urandom_range(8)) pl.push_back(8'($urandom_range(255)));
      if ($urandom_range(3) == 0)
        send_pkt(8'($urandom_range(255)), 8'($urandom_range(1, 255)));
      else
        send_pkt(8'($urandom_range(255)), 8'h00);
      if ($urandom_range(3) == 0) drain();
    end
    drain();

    rdy_pct = 100;
    ready_pct = 100;
    pl.delete();
    for (int k = 0; k < 260; k++) send_pkt(8'($urandom_range(255)), 8'h01);
    drain();
    chk8("err_cnt_saturated", err_cnt, 8'hFF);

    fifo.push_back(8'hA5);
    fifo.push_back(8'h10);
    fifo.push_back(8'h03);
    n = 0;
    while (fifo.size() != 0 && n < 100) begin
      @(negedge clk_rx);
      n++;
    end
    repeat (3) @(negedge clk_rx);
    @(posedge clk_rx);
    #2 rst_clk_rx = 1'b1;
    fifo.delete();
    model_err = 0;
    repeat (2) @(posedge clk_rx);
    #2 rst_clk_rx = 1'b0;
    @(negedge clk_rx);
    chk8("post_reset_err_cnt", err_cnt, 8'd0);
    chk8("post_reset_valid", {7'd0, out_valid}, 8'd0);
    pl = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h10, 8'h00);
    drain();
    chk8("post_reset_err_cnt_after_pkt", err_cnt, 8'd0);

`ifdef DEFRAMER_TIMEOUT_EN
    begin
      pay_t p;
      evt_t e;
      fifo.push_back(8'hA5);
      fifo.push_back(8'h10);
      fifo.push_back(8'h05);
      fifo.push_back(8'h11);
      p.cmd = 8'h10;
      p.data = 8'h11;
      p.last = 1'b0;
      pay_q.push_back(p);
      e.done = 1'b0;
      e.err = 1'b1;
      evt_q.push_back(e);
      repeat (60) @(negedge clk_rx);
      chk8("timeout_evt_consumed", 8'(evt_q.size()), 8'd0);
      pl = '{8'h77, 8'h88};
      send_pkt(8'h55, 8'h00);
      drain();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_pkt_deframer.md
# uart_pkt_deframer

Consumes the byte stream from the UART receiver's FIFO and recovers framed command packets (SYNC, CMD, LEN, payload, CHK). It pops bytes from the receiver FIFO with `read_en` and forwards payload bytes downstream on a valid/ready interface tagged with the packet command. At packet end it reports checksum pass or fail. It sits between the UART receiver and the board-level command/weight-loading logic.

## Interface
- `SYNC_BYTE`, 8'hA5: start-of-packet marker.
- `TIMEOUT_CYCLES`, 500_000: maximum idle clocks between bytes inside a packet (only used with `DEFRAMER_TIMEOUT_EN`).
- `clk_rx  in  1`: clock.
- `rst_clk_rx  in  1`: reset, active-high, synchronous to `clk_rx`.
- `rx_data  in  8`: head byte of the receiver FIFO. It is valid whenever `rx_data_rdy` is high (first-word-fall-through).
- `rx_data_rdy  in  1`: receiver FIFO is non-empty.
- `read_en  out  1`: pops one FIFO entry in the cycle it is high.
- `out_data  out  8`: payload byte.
- `out_cmd  out  8`: CMD byte of the current packet, held for the whole packet.
- `out_valid  out  1`: `out_data` is valid.
- `out_ready  in  1`: downstream accepts. A transfer occurs when `out_valid && out_ready`.
- `out_last  out  1`: marks the final payload byte.
- `pkt_done  out  1`: one-cycle pulse when CHK is consumed.
- `pkt_err  out  1`: one-cycle pulse coincident with `pkt_done` on checksum mismatch, or alone on timeout.
- `err_cnt  out  8`: saturating count of `pkt_err` pulses.

## Operation
- States: HUNT, CMD, LEN, PAYLOAD, CHK.
- **HUNT:** pop every available byte. A byte equal to `SYNC_BYTE` moves to CMD. All other bytes are discarded silently.
- **CMD:** pop a byte and latch it into `out_cmd`. Initialise the running checksum to that byte. Go to LEN.
- **LEN:** pop a byte and latch it into `len_rem` (8 bits). XOR it into the checksum.
  - LEN = 0: go to CHK.
  - Otherwise: go to PAYLOAD.
- **PAYLOAD:**
  - A byte is popped only when `rx_data_rdy` is high and the output register is empty or being drained in the same cycle (`!out_valid || out_ready`).
  - Each popped byte loads the output register, is XORed into the checksum, and decrements `len_rem`.
  - `out_last` is set when `len_rem` = 1 at the pop.
  - After the last pop, go to CHK. CHK may consume its byte while the last payload byte is still stalled at the output.
- **CHK:** pop a byte and compare it with the checksum.
  - Assert `pkt_done`. Assert `pkt_err` on mismatch.
  - Go to HUNT.
- A SYNC value inside CMD, LEN, PAYLOAD or CHK is ordinary data; there is no resynchronisation.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes. SYNC is excluded.
- Payload is forwarded before the checksum is known. Downstream must discard the packet when `pkt_err` accompanies `pkt_done`.
- `err_cnt` increments on each `pkt_err` and saturates at 255.
- `read_en` is combinational from state, `rx_data_rdy` and the output-register condition. It is never high while `rx_data_rdy` is low.

## Timing
- Reset values:
  - `read_en` = 0
  - `out_valid` = 0, `out_last` = 0
  - `out_data` = 0, `out_cmd` = 0
  - `pkt_done` = 0, `pkt_err` = 0
  - `err_cnt` = 0
  - state = HUNT
- Reset mid-packet abandons the packet. No `pkt_done` or `pkt_err` is emitted for it, and `out_valid` drops on the next edge.
- Latency: a byte popped in cycle T appears as `out_valid`/`out_data` in cycle T+1.
- `pkt_done` and `pkt_err` are registered and appear in the cycle after the CHK pop.
- Throughput: one byte per clock when the FIFO is non-empty and `out_ready` is high.
- Backpressure:
  - `out_valid` holds, with `out_data` and `out_last` stable, until accepted.
  - No byte is popped in PAYLOAD while the output is stalled.
- Simultaneous accept and pop: the output register reloads in the same cycle, with no bubble.

## Configuration
- `DEFRAMER_TIMEOUT_EN` defined:
  - An idle counter runs in every state except HUNT and clears on each pop.
  - When it reaches `TIMEOUT_CYCLES`, pulse `pkt_err` (no `pkt_done`), increment `err_cnt`, and return to HUNT.
  - If a payload byte is pending in the output register, it still drains normally, but its `out_last` is not forced.
- `DEFRAMER_TIMEOUT_EN` undefined: no counter. The block waits indefinitely for the remaining bytes of a packet.

## Structure
- Shared package `uart_pkt_pkg` contains:
  - the state enumeration (3-bit encoding);
  - the default `SYNC_BYTE`;
  - the checksum width constant.
- No sub-module is required for the FSM and datapath. The optional idle counter is a natural sub-module, `pkt_idle_timer` (inputs `clear`, `run`; output `expired`).

## Test plan
- **Nominal packet:** stream A5 10 03 11 22 33 CHK=10^03^11^22^33=0x13 with `out_ready`=1 → three bytes 11, 22, 33 with `out_cmd`=10 and `out_last` on 33. `pkt_done`=1, `pkt_err`=0.
- **Bad checksum:** same packet with CHK=0x14 → same payload output, then `pkt_done`=1, `pkt_err`=1, `err_cnt`=1.
- **Junk and zero-length:** 00 FF A5 20 00 CHK=0x20 → junk bytes discarded, no `out_valid`, `pkt_done`=1, `pkt_err`=0.
- **Backpressure:** 4-byte payload with `out_ready` low for 5 cycles after the first byte → `read_en` stays low during the stall, bytes arrive in order, none are lost or duplicated.
- **Reset mid-packet:** assert reset after LEN, then send a valid packet → first packet produces no `pkt_done`, second is received correctly, `err_cnt`=0.
- **Timeout** (with `DEFRAMER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50): send A5 10 05 11 then idle for 60 cycles → `pkt_err` pulses once, state returns to HUNT, and a following valid packet is accepted.
